// File: rtl/video_rx.sv
// video_rx: video timing receiver and frame-geometry lock detector.
//
// Registers the incoming sync/blank/pixel bus once and detects sync rising edges
// against a second registered copy. Counts columns and rows, measures the active
// geometry of every line and frame, and locks after two consecutive frames that
// match HDISP x VDISP. Pixel outputs appear two clocks after the input register
// samples them, and are qualified only while locked.
//
// Optional feature: define VIDEO_RX_CRC_EN to compile in a CRC-16-CCITT
// (poly 0x1021, init 0xFFFF, 24 bits per pixel MSB first) over each frame's
// active pixels. Without it frame_crc and crc_valid are tied to 0.
//
// Parameters:
//   HDISP         expected active pixels per line
//   VDISP         expected active lines per frame
// Ports:
//   pixel_clk     pixel clock, all logic on its rising edge
//   pixel_rst_n   synchronous active-low reset
//   vid_hs/vid_vs active-high horizontal / vertical sync
//   vid_blank     1 = blanking, 0 = active pixel
//   vid_rgb       pixel data {R,G,B}
//   pix_valid     active pixel qualifier (only while locked)
//   pix_rgb       registered pixel data
//   pix_x/pix_y   column / row of the current pixel
//   pix_sof       first active pixel of a frame
//   pix_eol       pixel with pix_x == HDISP-1
//   locked        geometry matches HDISP x VDISP
//   meas_hactive  active pixel count of the last active line
//   meas_vactive  active line count of the last frame
//   err_cnt       saturating count of lock losses
//   frame_crc     CRC of the last frame (0 without VIDEO_RX_CRC_EN)
//   crc_valid     one-cycle strobe for frame_crc
module video_rx #(
  parameter int unsigned HDISP = 800,
  parameter int unsigned VDISP = 480
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst_n,
  input  logic        vid_hs,
  input  logic        vid_vs,
  input  logic        vid_blank,
  input  logic [23:0] vid_rgb,
  output logic        pix_valid,
  output logic [23:0] pix_rgb,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        locked,
  output logic [11:0] meas_hactive,
  output logic [11:0] meas_vactive,
  output logic [7:0]  err_cnt,
  output logic [15:0] frame_crc,
  output logic        crc_valid
);

  localparam logic [11:0] HAct  = 12'(HDISP);
  localparam logic [11:0] HLast = 12'(HDISP - 1);
  localparam logic [11:0] VAct  = 12'(VDISP);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAcq    = 2'd1,
    StLocked = 2'd2
  } state_e;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hfff) ? v : v + 12'd1;
  endfunction

  // Input register stage and its delayed copy for edge detection
  logic        hs_q, vs_q, blank_q;
  logic [23:0] rgb_q;
  logic        hs_dly_q, vs_dly_q;

  // Counters and measurements
  logic [11:0] col_q, col_d;
  logic [11:0] row_q, row_d;
  logic        bad_q, bad_d;
  logic        sof_pend_q, sof_pend_d;
  logic [11:0] hact_q, hact_d;
  logic [11:0] vact_q, vact_d;

  // Next-pixel stage, one clock ahead of the outputs
  logic        p_act_q, p_sof_q, p_eol_q;
  logic [11:0] p_x_q, p_y_q;
  logic [23:0] p_rgb_q;

  // Lock FSM
  state_e      state_q, state_d;
  logic [1:0]  good_q, good_d;
  logic [7:0]  err_q, err_d;

  // Combinational helpers
  logic        hs_rise, vs_rise, act;
  logic        line_close, line_bad, frame_good;
  logic [11:0] rows_done, col_base, row_base;
  logic        sof_now, eol_now, out_gate;

  always_comb begin
    hs_rise    = hs_q & ~hs_dly_q;
    vs_rise    = vs_q & ~vs_dly_q;
    // Pixels are ignored until the first VS rise moves the FSM out of IDLE
    act        = ~blank_q && (state_q != StIdle);
    // A line with at least one active pixel closes on the next sync rise
    line_close = (hs_rise || vs_rise) && (col_q != 12'd0);
    line_bad   = (col_q != HAct);
    rows_done  = line_close ? sat_inc(row_q) : row_q;
    frame_good = (rows_done == VAct) && !bad_q && !(line_close && line_bad);

    col_base   = (hs_rise || vs_rise) ? 12'd0 : col_q;
    // VS rise wins over a simultaneous HS rise
    row_base   = vs_rise ? 12'd0 : rows_done;

    col_d      = act ? sat_inc(col_base) : col_base;
    row_d      = row_base;
    bad_d      = vs_rise ? 1'b0 : (bad_q | (line_close & line_bad));
    hact_d     = line_close ? col_q : hact_q;
    vact_d     = vs_rise ? rows_done : vact_q;

    sof_now    = act && (sof_pend_q || vs_rise);
    sof_pend_d = (sof_pend_q || vs_rise) && !act;
    eol_now    = act && (col_base == HLast);
  end

  // Next-state logic for the lock FSM
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = err_q;
    if (vs_rise) begin
      unique case (state_q)
        StIdle: begin
          state_d = StAcq;
          good_d  = 2'd0;
        end
        StAcq: begin
          if (frame_good) begin
            if (good_q + 2'd1 == 2'd2) begin
              state_d = StLocked;
              good_d  = 2'd0;
            end else begin
              good_d = good_q + 2'd1;
            end
          end else begin
            good_d = 2'd0;
          end
        end
        StLocked: begin
          if (!frame_good) begin
            state_d = StAcq;
            good_d  = 2'd0;
            err_d   = (err_q == 8'hff) ? err_q : err_q + 8'd1;
          end
        end
        default: begin
          state_d = StIdle;
          good_d  = 2'd0;
        end
      endcase
    end
    // Qualify outputs with the lock state they will be seen alongside
    out_gate = (state_d == StLocked);
  end

  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      state_q <= StIdle;
      good_q  <= 2'd0;
      err_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      blank_q    <= 1'b0;
      rgb_q      <= 24'd0;
      hs_dly_q   <= 1'b0;
      vs_dly_q   <= 1'b0;
      col_q      <= 12'd0;
      row_q      <= 12'd0;
      bad_q      <= 1'b0;
      sof_pend_q <= 1'b0;
      hact_q     <= 12'd0;
      vact_q     <= 12'd0;
      p_act_q    <= 1'b0;
      p_sof_q    <= 1'b0;
      p_eol_q    <= 1'b0;
      p_x_q      <= 12'd0;
      p_y_q      <= 12'd0;
      p_rgb_q    <= 24'd0;
      pix_valid  <= 1'b0;
      pix_sof    <= 1'b0;
      pix_eol    <= 1'b0;
      pix_x      <= 12'd0;
      pix_y      <= 12'd0;
      pix_rgb    <= 24'd0;
    end else begin
      hs_q       <= vid_hs;
      vs_q       <= vid_vs;
      blank_q    <= vid_blank;
      rgb_q      <= vid_rgb;
      hs_dly_q   <= hs_q;
      vs_dly_q   <= vs_q;
      col_q      <= col_d;
      row_q      <= row_d;
      bad_q      <= bad_d;
      sof_pend_q <= sof_pend_d;
      hact_q     <= hact_d;
      vact_q     <= vact_d;
      p_act_q    <= act;
      p_sof_q    <= sof_now;
      p_eol_q    <= eol_now;
      p_x_q      <= col_base;
      p_y_q      <= row_base;
      p_rgb_q    <= rgb_q;
      pix_valid  <= p_act_q & out_gate;
      pix_sof    <= p_sof_q & out_gate;
      pix_eol    <= p_eol_q & out_gate;
      pix_x      <= p_x_q;
      pix_y      <= p_y_q;
      pix_rgb    <= p_rgb_q;
    end
  end

  assign locked       = (state_q == StLocked);
  assign meas_hactive = hact_q;
  assign meas_vactive = vact_q;
  assign err_cnt      = err_q;

`ifdef VIDEO_RX_CRC_EN
  logic [15:0] crc_q, crc_d, crc_base;
  logic [15:0] frame_crc_q, frame_crc_d;
  logic        crc_valid_q, crc_valid_d;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 23; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    // A pixel on the VS-rise cycle already belongs to the new frame
    crc_base    = vs_rise ? 16'hffff : crc_q;
    crc_d       = act ? crc_step(crc_base, rgb_q) : crc_base;
    frame_crc_d = frame_crc_q;
    crc_valid_d = 1'b0;
    if (vs_rise && (state_q != StIdle)) begin
      frame_crc_d = crc_q;
      crc_valid_d = 1'b1;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      crc_q       <= 16'd0;
      frame_crc_q <= 16'd0;
      crc_valid_q <= 1'b0;
    end else begin
      crc_q       <= crc_d;
      frame_crc_q <= frame_crc_d;
      crc_valid_q <= crc_valid_d;
    end
  end

  assign frame_crc = frame_crc_q;
  assign crc_valid = crc_valid_q;
`else
  assign frame_crc = 16'd0;
  assign crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_video_rx.sv
// Self-checking bench for video_rx on a reduced 16x12 geometry.
// Frame-level records (sync, expected lock state and measurements, body shape)
// are applied from a table; a pixel scoreboard checks every qualified pixel.
// Hand-written sequences cover simultaneous HS/VS, output latency, reset
// mid-line, and the per-frame CRC.
module tb_video_rx;
  localparam int HD = 16;
  localparam int VD = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hs = 1'b0;
  logic        vs = 1'b0;
  logic        blank = 1'b1;
  logic [23:0] rgb = 24'd0;

  logic        pix_valid, pix_sof, pix_eol, locked, crc_valid;
  logic [23:0] pix_rgb;
  logic [11:0] pix_x, pix_y, meas_hactive, meas_vactive;
  logic [7:0]  err_cnt;
  logic [15:0] frame_crc;

  video_rx #(
    .HDISP(HD),
    .VDISP(VD)
  ) dut (
    .pixel_clk   (clk),
    .pixel_rst_n (rst_n),
    .vid_hs      (hs),
    .vid_vs      (vs),
    .vid_blank   (blank),
    .vid_rgb     (rgb),
    .pix_valid   (pix_valid),
    .pix_rgb     (pix_rgb),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_sof     (pix_sof),
    .pix_eol     (pix_eol),
    .locked      (locked),
    .meas_hactive(meas_hactive),
    .meas_vactive(meas_vactive),
    .err_cnt     (err_cnt),
    .frame_crc   (frame_crc),
    .crc_valid   (crc_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nlines;      // active lines in the body sent after the VS
    int short_line;  // line carrying HD-1 pixels, -1 for none
    bit exp_locked;  // lock state expected after the VS, also during the body
    int exp_err;
    int exp_hact;
    int exp_vact;
    bit ff;          // all-0xFFFFFF pixel data
  } rec_t;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic [23:0] rgb;
    logic        sof;
    logic        eol;
  } px_t;

  px_t         exp_q[$];
  px_t         mon_e;
  rec_t        tbl[12];
  int          n_tests = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b1;
  int          crc_pulses = 0;
  int          crc_total = 0;
  logic [15:0] crc_seen = 16'd0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] pat(input int x, input int y);
    logic [31:0] xv, yv;
    xv = x;
    yv = y;
    return {xv[7:0], yv[7:0], 8'h5a};
  endfunction

  function automatic logic [15:0] crc_ff_frame();
    logic [15:0] c;
    c = 16'hffff;
    for (int p = 0; p < HD * VD; p++) begin
      for (int i = 0; i < 24; i++) begin
        if (c[15] ^ 1'b1) c = {c[14:0], 1'b0} ^ 16'h1021;
        else              c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  task automatic drive(input bit h, input bit v, input bit b, input logic [23:0] d);
    @(negedge clk);
    hs    = h;
    vs    = v;
    blank = b;
    rgb   = d;
  endtask

  task automatic push_px(input int x, input int y, input logic [23:0] d);
    px_t e;
    e.x   = 12'(x);
    e.y   = 12'(y);
    e.rgb = d;
    e.sof = (x == 0) && (y == 0);
    e.eol = (x == HD - 1);
    exp_q.push_back(e);
  endtask

  task automatic send_line(input int len, input int y, input bit push, input bit ff);
    logic [23:0] d;
    repeat (2) drive(1'b1, 1'b0, 1'b1, 24'd0);
    repeat (2) drive(1'b0, 1'b0, 1'b1, 24'd0);
    for (int x = 0; x < len; x++) begin
      d = ff ? 24'hffffff : pat(x, y);
      drive(1'b0, 1'b0, 1'b0, d);
      if (push) push_px(x, y, d);
    end
    repeat (2) drive(1'b0, 1'b0, 1'b1, 24'd0);
  endtask

  task automatic send_vsync();
    repeat (4) drive(1'b0, 1'b1, 1'b1, 24'd0);
    repeat (2) drive(1'b0, 1'b0, 1'b1, 24'd0);
    repeat (2) send_line(0, 0, 1'b0, 1'b0);
  endtask

  task automatic send_body(input rec_t r);
    for (int y = 0; y < r.nlines; y++)
      send_line((y == r.short_line) ? HD - 1 : HD, y, r.exp_locked, r.ff);
    send_line(0, 0, 1'b0, 1'b0);  // trailing HS closes the last line
  endtask

  task automatic check_state(input rec_t r);
    check("locked", 128'(locked), 128'(r.exp_locked));
    check("err_cnt", 128'(err_cnt), 128'(r.exp_err));
    check("meas_hactive", 128'(meas_hactive), 128'(r.exp_hact));
    check("meas_vactive", 128'(meas_vactive), 128'(r.exp_vact));
`ifndef VIDEO_RX_CRC_EN
    check("crc_tied_off", 128'({frame_crc, crc_valid}), 128'(0));
`endif
  endtask

  task automatic run_record(input rec_t r);
    send_vsync();
    check_state(r);
    send_body(r);
  endtask

  task automatic check_all_zero(input string name);
    check(name, 128'({pix_valid, pix_rgb, pix_x, pix_y, pix_sof, pix_eol, locked,
                      meas_hactive, meas_vactive, err_cnt, frame_crc, crc_valid}), 128'(0));
  endtask

  // Pixel scoreboard and CRC strobe monitor
  always @(negedge clk) begin
    if (crc_valid) begin
      crc_pulses++;
      crc_total++;
      crc_seen = frame_crc;
    end
    if (mon_en && pix_valid) begin
      if (exp_q.size() == 0) begin
        check("pix_valid_unexpected", 128'(pix_valid), 128'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("pixel", 128'({pix_x, pix_y, pix_rgb, pix_sof, pix_eol}),
              128'({mon_e.x, mon_e.y, mon_e.rgb, mon_e.sof, mon_e.eol}));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [15:0] crc_exp;
    rec_t r;

    tbl[0]  = '{VD,     -1, 1'b0, 0, 0,  0,      1'b0};  // first VS: IDLE -> ACQ
    tbl[1]  = '{VD,     -1, 1'b0, 0, HD, VD,     1'b0};
    tbl[2]  = '{VD,     -1, 1'b1, 0, HD, VD,     1'b0};  // third VS locks
    tbl[3]  = '{VD,     10, 1'b1, 0, HD, VD,     1'b0};  // body has a short line 10
    tbl[4]  = '{VD,     -1, 1'b0, 1, HD, VD,     1'b0};  // lock lost
    tbl[5]  = '{VD,     -1, 1'b0, 1, HD, VD,     1'b0};
    tbl[6]  = '{VD,     -1, 1'b1, 1, HD, VD,     1'b0};  // relocked
    tbl[7]  = '{VD - 1, -1, 1'b1, 1, HD, VD,     1'b0};  // body one line short
    tbl[8]  = '{VD,     -1, 1'b0, 2, HD, VD - 1, 1'b0};
    tbl[9]  = '{VD,     -1, 1'b0, 2, HD, VD,     1'b0};
    tbl[10] = '{VD,     -1, 1'b1, 2, HD, VD,     1'b0};
    tbl[11] = '{VD,     -1, 1'b1, 2, HD, VD,     1'b0};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;

    // Active video before the first VS must be ignored
    r = '{VD, -1, 1'b0, 0, 0, 0, 1'b0};
    send_body(r);

    for (int i = 0; i < 12; i++) run_record(tbl[i]);

    // HS and VS rising together: row restarts at 0, first pixel is (0,0) with SOF
    drive(1'b1, 1'b1, 1'b1, 24'd0);
    drive(1'b1, 1'b1, 1'b1, 24'd0);
    repeat (2) drive(1'b0, 1'b1, 1'b1, 24'd0);
    repeat (2) drive(1'b0, 1'b0, 1'b1, 24'd0);
    check("locked_after_hsvs", 128'(locked), 128'(1));
    for (int x = 0; x < HD; x++) begin
      @(negedge clk);
      if (x == 2) check("latency_n1", 128'(pix_valid), 128'(0));
      if (x == 3)
        check("latency_n2", 128'({pix_valid, pix_x, pix_y, pix_sof}),
              128'({1'b1, 12'd0, 12'd0, 1'b1}));
      hs    = 1'b0;
      vs    = 1'b0;
      blank = 1'b0;
      rgb   = pat(x, 0);
      push_px(x, 0, pat(x, 0));
    end
    repeat (2) drive(1'b0, 1'b0, 1'b1, 24'd0);
    for (int y = 1; y < VD; y++) send_line(HD, y, 1'b1, 1'b0);
    send_line(0, 0, 1'b0, 1'b0);

    // All-0xFFFFFF frame, then the VS that closes it carries its CRC
    r = '{VD, -1, 1'b1, 2, HD, VD, 1'b1};
    run_record(r);
    crc_pulses = 0;
    send_vsync();
    check("locked_after_ff_frame", 128'(locked), 128'(1));
`ifdef VIDEO_RX_CRC_EN
    crc_exp = crc_ff_frame();
    check("crc_valid_pulses", 128'(crc_pulses), 128'(1));
    check("frame_crc", 128'(crc_seen), 128'(crc_exp));
`else
    crc_exp = 16'd0;
    check("crc_valid_pulses", 128'(crc_pulses), 128'(0));
    check("frame_crc", 128'(frame_crc), 128'(crc_exp));
`endif

    // One-cycle reset in the middle of a line while locked
    mon_en = 1'b0;
    repeat (2) drive(1'b1, 1'b0, 1'b1, 24'd0);
    repeat (2) drive(1'b0, 1'b0, 1'b1, 24'd0);
    for (int x = 0; x < 5; x++) drive(1'b0, 1'b0, 1'b0, pat(x, 0));
    drive(1'b0, 1'b0, 1'b0, pat(5, 0));
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midline_reset_outputs");
    rst_n = 1'b1;
    for (int x = 6; x < HD; x++) drive(1'b0, 1'b0, 1'b0, pat(x, 0));
    repeat (2) drive(1'b0, 1'b0, 1'b1, 24'd0);
    exp_q.delete();
    mon_en = 1'b1;
    send_line(HD, 1, 1'b0, 1'b0);
    send_line(0, 0, 1'b0, 1'b0);

    r = '{VD, -1, 1'b0, 0, 0,  0,  1'b0};
    run_record(r);
    r = '{VD, -1, 1'b0, 0, HD, VD, 1'b0};
    run_record(r);
    r = '{VD, -1, 1'b1, 0, HD, VD, 1'b0};
    run_record(r);
    send_vsync();
    check("locked_final", 128'(locked), 128'(1));

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
`ifndef VIDEO_RX_CRC_EN
    check("crc_valid_never", 128'(crc_total), 128'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/video_rx.md
VIDEO_RX -- requirements
Module: video_rx

Interface
REQ-001 Parameters SHALL be: HDISP, default 800, expected active pixels per line; VDISP, default 480, expected active lines per frame.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- pixel_clk  in  1  pixel clock; all logic on its rising edge.
- pixel_rst_n  in  1  synchronous reset, active-low.
- vid_hs  in  1  horizontal sync, active-high.
- vid_vs  in  1  vertical sync, active-high.
- vid_blank  in  1  1 = blanking, 0 = active pixel.
- vid_rgb  in  24  pixel data {R,G,B}, 8 bits each.
- pix_valid  out  1  active pixel output qualifier.
- pix_rgb  out  24  registered pixel data.
- pix_x  out  12  column of the current pixel.
- pix_y  out  12  row of the current pixel.
- pix_sof  out  1  first active pixel of a frame.
- pix_eol  out  1  last active pixel of a line.
- locked  out  1  frame geometry matches HDISP x VDISP.
- meas_hactive  out  12  active pixel count of the last active line.
- meas_vactive  out  12  active line count of the last frame.
- err_cnt  out  8  count of lock losses, saturating.
- frame_crc  out  16  CRC of the last frame (see Configuration).
- crc_valid  out  1  one-cycle strobe for frame_crc.

Function
REQ-003 All video inputs SHALL be registered once; edge detection SHALL compare this registered stage to a second registered copy.
REQ-004 The pix_* outputs for an input sampled at edge n SHALL update at edge n+2.
REQ-005 HS rise (registered 0->1) SHALL clear the column counter; the first active pixel after it SHALL carry pix_x=0; pix_x SHALL saturate at 4095.
REQ-006 A line SHALL be active if it held at least 1 active pixel; on HS rise after an active line, the row counter SHALL increment and meas_hactive SHALL latch that line's count.
REQ-007 VS rise SHALL clear the row counter, latch meas_vactive, and evaluate the completed frame; VS rise SHALL take priority over a simultaneous HS rise for the row counter.
REQ-008 A frame SHALL be good if meas_vactive==VDISP and every active line had exactly HDISP pixels; pix_eol SHALL still be produced only from the next-pixel state, so pix_eol SHALL mark the pixel with pix_x==HDISP-1.
REQ-009 The FSM SHALL have the states IDLE, ACQ and LOCKED: IDLE->ACQ on the first VS rise with no evaluation; in ACQ, a good frame SHALL increment a 2-bit good counter, reaching LOCKED at 2, and a bad frame SHALL clear the counter; LOCKED->ACQ on a bad frame, with err_cnt+1 saturating at 255.
REQ-010 locked SHALL be 1 only in LOCKED; pix_valid, pix_sof and pix_eol SHALL be asserted only while locked is 1 on the active pixel.
REQ-011 pix_sof SHALL be asserted with pix_x=0, pix_y=0 on the first active pixel after VS rise.
REQ-012 Active pixels seen before the first VS rise after reset SHALL be ignored.

Reset
REQ-013 With pixel_rst_n low at a clock edge, the block SHALL enter IDLE and SHALL clear every output, counter and input register to 0; reset mid-frame SHALL discard the partial frame.

Configuration
REQ-014 Defining VIDEO_RX_CRC_EN SHALL compile in a CRC-16-CCITT (poly 0x1021, init 0xFFFF, 24 bits per pixel, MSB first) over all active pixels of a frame, with frame_crc updated and crc_valid pulsed for 1 cycle at VS rise in any state except IDLE.
REQ-015 Without VIDEO_RX_CRC_EN, frame_crc and crc_valid SHALL be tied to 0 and no CRC logic SHALL exist.

Verification
REQ-016 The bench SHALL cover the following scenarios:
- 3 nominal 800x480 frames -> locked=1 at the 3rd VS rise; pix_sof at (0,0); pix_eol at pix_x=799; meas_hactive=800, meas_vactive=480.
- Locked, then 1 frame with 799-pixel line 10 -> locked=0 at the following VS rise; err_cnt=1; 2 good frames relock.
- Locked, then a frame of 479 lines -> same response as the previous scenario; meas_vactive=479.
- HS and VS rising on the same cycle -> row counter=0; next active pixel (0,0) with pix_sof.
- pixel_rst_n low for 1 cycle mid-line while locked -> all outputs 0; IDLE; lock again after the 3rd VS rise.
- With VIDEO_RX_CRC_EN defined, a frame of all-0xFFFFFF pixels -> frame_crc matches the reference model; crc_valid high for exactly 1 cycle.
